mod_barrett_arbiter: RTL
========================

Name: mod_barrett_arbiter

Overview:
- Shares one combinational mod_barrett unit (out_1 = in_1 mod in_2, 32-bit operands) between NUM_REQ requesters. Typical requesters are NTT/polynomial engines in the PQ accelerator cluster.
- Round-robin arbitration, valid/ready handshakes on both sides.
- Two-stage buffer: operand register, then result register. Sustains one reduction per cycle.
- Results return on a single response channel, tagged with the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width; must match mod_barrett.
- ID_W, $clog2(NUM_REQ), requester tag width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_in_1  in  NUM_REQ*DATA_W  dividend; slice i belongs to requester i.
- req_in_2  in  NUM_REQ*DATA_W  modulus; slice i belongs to requester i.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  in_1 mod in_2.
- rsp_id  out  ID_W  index of originating requester.
- rsp_err  out  1  set when modulus was 0.
- ops_done  out  32  count of completed response handshakes; wraps at 2^32.

Behaviour:
- Reset (rst=1 at a clock edge, including mid-operation):
  - op_valid=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, ops_done=0.
  - RR pointer = NUM_REQ-1, so requester 0 has top priority after reset.
  - In-flight items are discarded, not completed.
  - req_ready=0 while rst is high.
- Stage advance: adv = op_valid & (~rsp_valid | rsp_ready).
- Accept enable: acc_en = ~op_valid | adv.
- Grant:
  - When acc_en=1, search for the first req_valid starting at ptr+1 (mod NUM_REQ).
  - req_ready is one-hot on the winner; zero if acc_en=0 or no request is valid.
  - req_ready is combinational from req_valid and state; req_valid must not depend on req_ready.
- On an accept handshake for requester g:
  - Latch in_1[g], in_2[g] and g into the op register; set op_valid=1.
  - Set ptr=g.
  - ptr is unchanged when nothing is accepted.
- Op stage:
  - Registered operands drive mod_barrett.
  - On adv, the result register loads {mod_barrett.out_1, id, err=0} and rsp_valid=1.
  - If in_2==0: load rsp_data=0, rsp_err=1; the mod_barrett output is ignored.
  - If adv=0, op_valid remains 1 and the op register is unchanged.
- Response stage:
  - rsp_data, rsp_id and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: ops_done increments by 1.
  - Same cycle, with adv: the result register reloads from the op stage and rsp_valid stays 1.
  - Same cycle, without adv: rsp_valid drops to 0.
- Latency and throughput:
  - Accept at edge t → rsp_valid visible in the cycle after edge t+1 (2 cycles).
  - 1 op/cycle when rsp_ready is held high.
- Backpressure: with rsp_ready=0, at most 2 items are buffered (rsp + op). After that, req_ready=0 for all requesters.
- Simultaneous response handshake and new accept in the same cycle is legal; no bubble.
- A requester holding req_valid with changing operands before acceptance is a protocol violation; the bench asserts operands are stable until req_ready.

Decomposition:
- Package mod_barrett_pkg:
  - DATA_W_DEF=32.
  - Typedef op_t = struct {in_1, in_2, id}.
  - Typedef rsp_t = struct {data, id, err}.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, ptr, en; outputs onehot grant and idx.
- The top instantiates rr_arbiter and mod_barrett.

Test Plan:
- Requester 0 sends in_1=59099, in_2=400, rsp_ready=1 → rsp_data=299, rsp_id=0, rsp_err=0, 2 cycles after accept; ops_done=1.
- All 4 requesters valid together at cycle t:
  - Requester 0: 10000 mod 3329.
  - Requester 1: 100000 mod 12289.
  - Requester 2: 7 mod 7.
  - Requester 3: 5 mod 9.
  - Required: grants in order 0,1,2,3 at t..t+3; responses 13, 1688, 0, 5 with ids 0..3 at t+2..t+5.
- Backpressure: rsp_ready=0 from the first response onward → exactly 2 accepts, then req_ready=0. rsp_data stays stable. After rsp_ready=1, both results drain in order with no loss.
- Modulus zero: requester 2 sends in_1=1234, in_2=0 → rsp_data=0, rsp_err=1, rsp_id=2.
- Fairness: requesters 1 and 3 held valid continuously → grants alternate 1,3,1,3. Requester 3 is never starved.
- Reset mid-operation: assert rst with 2 items buffered → next cycle rsp_valid=0, ops_done=0. The first grant after reset goes to the lowest-index valid requester.

Source files
------------

// File: rtl/mod_barrett_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_barrett_pkg
// Brief    : Shared types and constants for the shared modular-reduction arbiter.
// Revision : 1.0
// ============================================================================
package mod_barrett_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ID_MAX_W   = 3;   // wide enough for up to 8 requesters

    typedef struct packed {
        logic [DATA_W_DEF-1:0] in_1;
        logic [DATA_W_DEF-1:0] in_2;
        logic [ID_MAX_W-1:0]   id;
    } op_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [ID_MAX_W-1:0]   id;
        logic                  err;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/mod_barrett.sv
`default_nettype none
// ============================================================================
// Module   : mod_barrett
// Brief    : Combinational reduction out_1 = in_1 mod in_2 (0 when in_2 is 0).
// Revision : 1.0
// ============================================================================
module mod_barrett #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    output logic [DATA_W-1:0] out_1
);

    always_comb begin
        out_1 = '0;
        if (in_2 != '0) begin
            out_1 = in_1 % in_2;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin grant search starting one past the last winner.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        logic found;
        int   cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = ID_W'(cand);
                found       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_barrett_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mod_barrett_arbiter
// Brief    : Round-robin sharing of one mod unit, operand + result register pipe.
// Revision : 1.0
// ============================================================================
module mod_barrett_arbiter
    import mod_barrett_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_in_1,
    input  logic [NUM_REQ*DATA_W-1:0] req_in_2,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_err,
    output logic [31:0]               ops_done
);

    op_t                r_op;
    logic               r_op_valid;
    rsp_t               r_rsp;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_ptr;
    logic [31:0]        r_ops_done;

    logic               w_adv;
    logic               w_acc_en;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_acc;
    logic [DATA_W-1:0]  w_in_1;
    logic [DATA_W-1:0]  w_in_2;
    logic [DATA_W-1:0]  w_mod_out;
    logic               w_unused_id;

    assign w_adv    = r_op_valid & (~r_rsp_valid | rsp_ready);
    assign w_acc_en = ~r_op_valid | w_adv;

    // Grants are suppressed during reset so nothing is handshaked into a discarded pipe.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (r_ptr),
        .en    (w_acc_en & ~rst),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign req_ready = w_grant;
    assign w_acc     = |w_grant;

    always_comb begin
        w_in_1 = '0;
        w_in_2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_in_1 = req_in_1[i*DATA_W +: DATA_W];
                w_in_2 = req_in_2[i*DATA_W +: DATA_W];
            end
        end
    end

    mod_barrett #(
        .DATA_W (DATA_W)
    ) u_mod_barrett (
        .in_1  (r_op.in_1),
        .in_2  (r_op.in_2),
        .out_1 (w_mod_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_op_valid  <= 1'b0;
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
            r_ptr       <= ID_W'(NUM_REQ - 1);
            r_ops_done  <= '0;
        end else begin
            if (w_acc) begin
                r_op.in_1  <= w_in_1;
                r_op.in_2  <= w_in_2;
                r_op.id    <= ID_MAX_W'(w_idx);
                r_op_valid <= 1'b1;
                r_ptr      <= w_idx;
            end else if (w_adv) begin
                r_op_valid <= 1'b0;
            end

            if (w_adv) begin
                r_rsp.id    <= r_op.id;
                r_rsp_valid <= 1'b1;
                if (r_op.in_2 == '0) begin
                    r_rsp.data <= '0;
                    r_rsp.err  <= 1'b1;
                end else begin
                    r_rsp.data <= w_mod_out;
                    r_rsp.err  <= 1'b0;
                end
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end

            if (r_rsp_valid && rsp_ready) begin
                r_ops_done <= r_ops_done + 32'd1;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp.data;
    assign rsp_id      = r_rsp.id[ID_W-1:0];
    assign rsp_err     = r_rsp.err;
    assign ops_done    = r_ops_done;
    assign w_unused_id = ^r_rsp.id;

endmodule
`default_nettype wire
